subdiv_job_launcher: RTL and testbench

//  Initiator side of the subdivision core's start/busy interface. Accepts a job

---
 rtl/subdiv_job_launcher.sv | 170 +++++++++++++++++
 tb/tb_subdiv_job_launcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subdiv_job_launcher.sv
// Subdivision job launcher: runs the subdivision core once per requested level
// over its start/busy handshake, guarding both the ack and run phases with
// watchdogs, and reports done/error plus the total job cycle count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a job; ready only while the core is not busy
//   LAUNCH   | first cycle of a start burst for the current level
//   WAIT_ACK | start held, waiting for busy to rise (ack watchdog running)
//   RUN      | core busy, waiting for busy to fall (run watchdog running)
//   GAP      | one extra start-low cycle between levels
//   DONE     | one-cycle completion pulse
//   ERR      | latched error, waiting for job_clr
module subdiv_job_launcher #(
  parameter int LEVEL_W     = 3,
  parameter int ACK_TIMEOUT = 16,
  parameter int RUN_W       = 20,
  parameter int CYC_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [LEVEL_W-1:0] job_levels,
  input  logic               job_clr,
  output logic               core_start,
  input  logic               core_busy,
  output logic               job_done,
  output logic               job_err,
  output logic [1:0]         err_code,
  output logic [LEVEL_W-1:0] level_idx,
  output logic [CYC_W-1:0]   cycle_count,
  output logic               active
);

  // The ack counter holds the number of start-high cycles already elapsed;
  // LAUNCH counts as the first, so the last allowed WAIT_ACK cycle sees
  // ACK_TIMEOUT-1 in the counter.
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ACK  = 2'd1;
  localparam logic [1:0] ERR_RUN  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] levels_q, levels_d;
  logic [LEVEL_W-1:0] level_idx_q, level_idx_d;
  logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [1:0]         err_code_q, err_code_d;

  logic [LEVEL_W-1:0] level_nxt;
  logic [RUN_W-1:0]   run_nxt;
  logic [CYC_W-1:0]   cyc_inc;

  assign level_nxt = level_idx_q + LEVEL_W'(1);
  assign run_nxt   = run_cnt_q + RUN_W'(1);
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      levels_q    <= '0;
      level_idx_q <= '0;
      ack_cnt_q   <= '0;
      run_cnt_q   <= '0;
      cyc_q       <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      levels_q    <= levels_d;
      level_idx_q <= level_idx_d;
      ack_cnt_q   <= ack_cnt_d;
      run_cnt_q   <= run_cnt_d;
      cyc_q       <= cyc_d;
      err_code_q  <= err_code_d;
    end
  end

  // Next-state and datapath updates for the level sequencing.
  always_comb begin
    state_d     = state_q;
    levels_d    = levels_q;
    level_idx_d = level_idx_q;
    ack_cnt_d   = ack_cnt_q;
    run_cnt_d   = run_cnt_q;
    cyc_d       = cyc_q;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (job_valid && !core_busy) begin
          levels_d    = job_levels;
          level_idx_d = '0;
          cyc_d       = '0;
          err_code_d  = ERR_NONE;
          state_d     = (job_levels == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cyc_d     = cyc_inc;
        ack_cnt_d = ACK_W'(1);
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        cyc_d = cyc_inc;
        if (core_busy) begin
          run_cnt_d = '0;
          state_d   = S_RUN;
        end else if (ack_cnt_q >= ACK_LAST) begin
          err_code_d = ERR_ACK;
          state_d    = S_ERR;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (!core_busy) begin
          level_idx_d = level_nxt;
          state_d     = (level_nxt == levels_q) ? S_DONE : S_GAP;
        end else begin
          run_cnt_d = run_nxt;
          if (&run_nxt) begin
            err_code_d = ERR_RUN;
            state_d    = S_ERR;
          end
        end
      end
      S_GAP: begin
        cyc_d   = cyc_inc;
        state_d = S_LAUNCH;
      end
      S_DONE: begin
        cyc_d   = cyc_inc;
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (job_clr) begin
          err_code_d = ERR_NONE;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_start  = (state_q == S_LAUNCH) || (state_q == S_WAIT_ACK);
  assign job_ready   = (state_q == S_IDLE) && !core_busy;
  assign job_done    = (state_q == S_DONE);
  assign job_err     = (state_q == S_ERR);
  assign active      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err_code    = err_code_q;
  assign level_idx   = level_idx_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_subdiv_job_launcher.sv
// Bench for subdiv_job_launcher: a schedule-driven core model plus a per-cycle
// expectation table built from the handshake latencies and watchdog limits.
module tb_subdiv_job_launcher;

  localparam int LEVEL_W     = 3;
  localparam int ACK_TIMEOUT = 16;
  localparam int RUN_W       = 4;
  localparam int CYC_W       = 32;
  localparam int RUN_MAX     = (1 << RUN_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [LEVEL_W-1:0] job_levels = '0;
  logic               job_clr = 1'b0;
  logic               core_start;
  logic               core_busy = 1'b0;
  logic               job_done;
  logic               job_err;
  logic [1:0]         err_code;
  logic [LEVEL_W-1:0] level_idx;
  logic [CYC_W-1:0]   cycle_count;
  logic               active;

  subdiv_job_launcher #(
    .LEVEL_W(LEVEL_W), .ACK_TIMEOUT(ACK_TIMEOUT), .RUN_W(RUN_W), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_levels(job_levels), .job_clr(job_clr), .core_start(core_start),
    .core_busy(core_busy), .job_done(job_done), .job_err(job_err),
    .err_code(err_code), .level_idx(level_idx), .cycle_count(cycle_count),
    .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle expectations, index 0 = first cycle after the accept edge.
  int q_busy[$], q_start[$], q_done[$], q_err[$], q_code[$];
  int q_lvl[$], q_cnt[$], q_act[$], q_rdy[$];
  int last_cnt = 0;
  int last_lvl = 0;
  int a_arr[8], b_arr[8];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_q();
    q_busy.delete(); q_start.delete(); q_done.delete(); q_err.delete(); q_code.delete();
    q_lvl.delete(); q_cnt.delete(); q_act.delete(); q_rdy.delete();
  endtask

  task automatic push_cyc(input int busy, input int start, input int done, input int err,
                          input int code, input int lvl, input int cnt, input int act,
                          input int rdy);
    q_busy.push_back(busy); q_start.push_back(start); q_done.push_back(done);
    q_err.push_back(err); q_code.push_back(code); q_lvl.push_back(lvl);
    q_cnt.push_back(cnt); q_act.push_back(act); q_rdy.push_back(rdy);
  endtask

  // Level i: start high for a cycles, busy high for b cycles beginning with the
  // last start cycle, busy fall sampled at f, then GAP and the next LAUNCH.
  task automatic build_job(input int lv);
    int s[8];
    int f[8];
    int t;
    int d;
    clear_q();
    t = 0;
    for (int i = 0; i < lv; i++) begin
      s[i] = t;
      f[i] = t + a_arr[i] + b_arr[i] - 1;
      t = f[i] + 2;
    end
    d = (lv == 0) ? 0 : f[lv-1] + 1;
    for (int j = 0; j <= d + 1; j++) begin
      int st, bz, lvl;
      st = 0; bz = 0; lvl = 0;
      for (int i = 0; i < lv; i++) begin
        if (j >= s[i] && j <= s[i] + a_arr[i] - 1) st = 1;
        if (j >= s[i] + a_arr[i] - 1 && j <= f[i] - 1) bz = 1;
        if (f[i] < j) lvl++;
      end
      if (j <= d) push_cyc(bz, st, (j == d) ? 1 : 0, 0, 0, lvl, j, 1, 0);
      else        push_cyc(0, 0, 0, 0, 0, lvl, d + 1, 0, 1);
    end
    last_cnt = d + 1;
    last_lvl = lv;
  endtask

  task automatic build_ack_to(input int hold);
    clear_q();
    for (int j = 0; j < ACK_TIMEOUT + hold; j++) begin
      if (j < ACK_TIMEOUT) push_cyc(0, 1, 0, 0, 0, 0, j, 1, 0);
      else                 push_cyc(0, 0, 0, 1, 1, 0, ACK_TIMEOUT, 0, 0);
    end
    last_cnt = ACK_TIMEOUT;
    last_lvl = 0;
  endtask

  task automatic build_run_to(input int a, input int hold);
    int e;
    clear_q();
    e = a + RUN_MAX;
    for (int j = 0; j < e + hold; j++) begin
      if (j < e) push_cyc((j >= a - 1) ? 1 : 0, (j < a) ? 1 : 0, 0, 0, 0, 0, j, 1, 0);
      else       push_cyc(1, 0, 0, 1, 2, 0, e, 0, 0);
    end
    last_cnt = e;
    last_lvl = 0;
  endtask

  task automatic play(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      core_busy = q_busy[j][0];
      job_clr   = (q_err[j] == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (q_rdy[j] == 0) begin
        job_valid  = 1'($urandom_range(0, 1));
        job_levels = LEVEL_W'($urandom);
      end else begin
        job_valid = 1'b0;
      end
      #1;
      check_val($sformatf("start@%0d", j), core_start, q_start[j]);
      check_val($sformatf("done@%0d", j), job_done, q_done[j]);
      check_val($sformatf("err@%0d", j), job_err, q_err[j]);
      check_val($sformatf("code@%0d", j), err_code, q_code[j]);
      check_val($sformatf("lvl@%0d", j), level_idx, q_lvl[j]);
      check_val($sformatf("cnt@%0d", j), cycle_count, q_cnt[j]);
      check_val($sformatf("act@%0d", j), active, q_act[j]);
      check_val($sformatf("rdy@%0d", j), job_ready, q_rdy[j]);
    end
    job_valid = 1'b0;
    job_clr   = 1'b0;
  endtask

  task automatic accept(input int lv, input int busy_wait);
    for (int i = 0; i < busy_wait; i++) begin
      @(negedge clk);
      core_busy = 1'b1; job_valid = 1'b1; job_levels = LEVEL_W'(lv); job_clr = 1'b0;
      #1;
      check_val("busy_idle_rdy", job_ready, 0);
      check_val("busy_idle_act", active, 0);
      check_val("busy_idle_start", core_start, 0);
    end
    @(negedge clk);
    core_busy = 1'b0; job_valid = 1'b1; job_levels = LEVEL_W'(lv); job_clr = 1'b0;
    #1;
    check_val("acc_rdy", job_ready, 1);
    check_val("acc_act", active, 0);
    check_val("acc_cnt", cycle_count, last_cnt);
    check_val("acc_lvl", level_idx, last_lvl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      job_valid = 1'b0;
      job_clr   = 1'($urandom_range(0, 1));
      core_busy = 1'($urandom_range(0, 1));
      #1;
      check_val("idle_rdy", job_ready, !core_busy);
      check_val("idle_act", active, 0);
      check_val("idle_start", core_start, 0);
      check_val("idle_done", job_done, 0);
      check_val("idle_err", job_err, 0);
      check_val("idle_cnt", cycle_count, last_cnt);
      check_val("idle_lvl", level_idx, last_lvl);
    end
    core_busy = 1'b0;
    job_clr   = 1'b0;
  endtask

  task automatic clr_err();
    @(negedge clk);
    job_clr = 1'b1; core_busy = 1'b0; job_valid = 1'b1;
    #1;
    check_val("clr_err_held", job_err, 1);
    check_val("clr_rdy_err", job_ready, 0);
    @(negedge clk);
    job_clr = 1'b0; job_valid = 1'b0;
    #1;
    check_val("clr_err", job_err, 0);
    check_val("clr_code", err_code, 0);
    check_val("clr_rdy", job_ready, 1);
    check_val("clr_act", active, 0);
    check_val("clr_cnt", cycle_count, last_cnt);
    check_val("clr_lvl", level_idx, last_lvl);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_start"}, core_start, 0);
    check_val({tag, "_done"}, job_done, 0);
    check_val({tag, "_err"}, job_err, 0);
    check_val({tag, "_code"}, err_code, 0);
    check_val({tag, "_lvl"}, level_idx, 0);
    check_val({tag, "_cnt"}, cycle_count, 0);
    check_val({tag, "_act"}, active, 0);
    check_val({tag, "_rdy"}, job_ready, 1);
  endtask

  task automatic rand_ab();
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = $urandom_range(2, 6);
      b_arr[i] = $urandom_range(1, 12);
    end
  endtask

  initial begin
    int lv;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Three levels, ack after 2 cycles, busy 10 cycles.
    for (int i = 0; i < 8; i++) begin a_arr[i] = 2; b_arr[i] = 10; end
    accept(3, 0);
    build_job(3);
    play(q_busy.size());

    // Zero levels, with the core busy in IDLE first.
    accept(0, 3);
    build_job(0);
    play(q_busy.size());

    // Ack watchdog.
    accept(1, 0);
    build_ack_to(3);
    play(q_busy.size());
    clr_err();

    // Run watchdog with busy stuck high.
    accept(2, 0);
    build_run_to(2, 3);
    play(q_busy.size());
    clr_err();

    for (int n = 0; n < 25; n++) begin
      idle($urandom_range(0, 3));
      lv = $urandom_range(0, 7);
      rand_ab();
      accept(lv, $urandom_range(0, 2));
      build_job(lv);
      play(q_busy.size());
    end

    // Reset while level 2 is running, then a fresh job.
    for (int i = 0; i < 8; i++) begin a_arr[i] = 3; b_arr[i] = 8; end
    accept(3, 0);
    build_job(3);
    play(17);
    @(negedge clk);
    rst_n = 1'b0; core_busy = 1'b0; job_valid = 1'b0; job_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset("midrst");
    last_cnt = 0;
    last_lvl = 0;
    rand_ab();
    accept(2, 0);
    build_job(2);
    play(q_busy.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
